// File: rtl/fp_normalize_pipe_if.sv
// rtl/fp_normalize_pipe_if.sv - handshake and data bundle for fp_normalize_pipe
//
// Input side : in_valid/in_ready with mode_fp, mant_in, exp_in, tag_in.
// Output side: out_valid/out_ready with mant_out, exp_out, flags, tag_out.
// master drives operations and accepts results; slave is the normalizer.
interface fp_normalize_pipe_if #(
    parameter int MANT_W = 49,
    parameter int EXP_W  = 9,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              mode_fp;
    logic [MANT_W-1:0] mant_in;
    logic [EXP_W-1:0]  exp_in;
    logic [TAG_W-1:0]  tag_in;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic [4:0]        flags;
    logic [TAG_W-1:0]  tag_out;

    modport master (
        output in_valid, mode_fp, mant_in, exp_in, tag_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, flags, tag_out
    );

    modport slave (
        input  in_valid, mode_fp, mant_in, exp_in, tag_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, flags, tag_out
    );
endinterface

// File: rtl/fp_normalize_pipe.sv
// rtl/fp_normalize_pipe.sv - two-stage elastic floating-point mantissa normalizer
//
// Stage 1 registers an accepted operation together with its carry bit, the
// leading-zero count of the hidden-bit field and the available exponent
// headroom. Stage 2 shifts, adjusts the exponent and registers the result
// and flags {overflow, underflow, inexact, zero, denormal}.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   bus (slave)         in_valid/in_ready/mode_fp/mant_in/exp_in/tag_in and
//                       out_valid/out_ready/mant_out/exp_out/flags/tag_out
//   stat_clr, ovf_cnt, unf_cnt, inx_cnt
//                       saturating flag counters, present only when the
//                       macro FP_NORM_STATS_EN is defined
module fp_normalize_pipe #(
    parameter int MANT_W = 49,
    parameter int EXP_W  = 9,
    parameter int TAG_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FP_NORM_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] ovf_cnt,
    output logic [15:0] unf_cnt,
    output logic [15:0] inx_cnt,
`endif
    fp_normalize_pipe_if.slave bus
);
    localparam int LZC_W = $clog2(MANT_W);
    localparam int CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;
    localparam int EW1   = EXP_W + 1;
    localparam logic [EXP_W:0] MAX_HALF = EW1'(30);
    localparam logic [EXP_W:0] MAX_SGL  = EW1'(254);

    // Stage 1 state
    logic              s1_valid_q;
    logic [MANT_W-1:0] s1_mant_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic              s1_mode_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic              s1_carry_q;
    logic [LZC_W-1:0]  s1_lzc_q;
    logic [EXP_W-1:0]  s1_head_q;

    // Stage 2 (output) state
    logic              out_valid_q;
    logic [MANT_W-1:0] mant_out_q;
    logic [EXP_W-1:0]  exp_out_q;
    logic [4:0]        flags_q;
    logic [TAG_W-1:0]  tag_out_q;

    logic             s2_free;
    logic             s1_advance;
    logic             in_fire;
    logic [LZC_W-1:0] lzc_d;
    logic [EXP_W-1:0] head_d;

    assign s2_free      = !out_valid_q || bus.out_ready;
    assign s1_advance   = s1_valid_q && s2_free;
    assign bus.in_ready = !s1_valid_q || s1_advance;
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Priority leading-zero count over the hidden-bit field; the highest set
    // bit is visited last and therefore wins.
    always_comb begin
        lzc_d = LZC_W'(MANT_W - 1);
        for (int i = 0; i < MANT_W - 1; i++) begin
            if (bus.mant_in[i]) lzc_d = LZC_W'(MANT_W - 2 - i);
        end
        head_d = (bus.exp_in == '0) ? '0 : bus.exp_in - EXP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_mode_q  <= 1'b0;
            s1_tag_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_lzc_q   <= '0;
            s1_head_q  <= '0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_mant_q  <= bus.mant_in;
            s1_exp_q   <= bus.exp_in;
            s1_mode_q  <= bus.mode_fp;
            s1_tag_q   <= bus.tag_in;
            s1_carry_q <= bus.mant_in[MANT_W-1];
            s1_lzc_q   <= lzc_d;
            s1_head_q  <= head_d;
        end else if (s1_advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    logic [EXP_W:0]    max_exp;
    logic [EXP_W:0]    exp_adj;
    logic [LZC_W-1:0]  shift;
    logic [MANT_W-1:0] mant_d;
    logic [EXP_W-1:0]  exp_d;
    logic [4:0]        flags_d;
    logic              ovf, unf, inx, zero, den;

    always_comb begin
        max_exp = s1_mode_q ? MAX_SGL : MAX_HALF;
        exp_adj = {1'b0, s1_exp_q};
        mant_d  = s1_mant_q;
        shift   = '0;
        ovf     = 1'b0;
        unf     = 1'b0;
        inx     = 1'b0;
        zero    = 1'b0;
        if (s1_mant_q == '0) begin
            zero    = 1'b1;
            exp_adj = '0;
        end else if (s1_carry_q) begin
            mant_d  = s1_mant_q >> 1;
            exp_adj = {1'b0, s1_exp_q} + EW1'(1);
            inx     = s1_mant_q[0];
        end else if (s1_exp_q == '0) begin
            unf = 1'b1;
        end else begin
            // Never shift past exponent 1; headroom < lzc implies it fits LZC_W.
            if (CMP_W'(s1_lzc_q) <= CMP_W'(s1_head_q)) shift = s1_lzc_q;
            else                                      shift = LZC_W'(s1_head_q);
            mant_d  = s1_mant_q << shift;
            exp_adj = {1'b0, s1_exp_q} - EW1'(shift);
        end
        // Widened arithmetic: a wrapped increment also lands above max_exp.
        if (!zero && (exp_adj > max_exp)) begin
            ovf     = 1'b1;
            exp_adj = max_exp + EW1'(1);
        end
        exp_d   = exp_adj[EXP_W-1:0];
        den     = !zero && (exp_d == EXP_W'(1)) && !mant_d[MANT_W-2];
        flags_d = {ovf, unf, inx, zero, den};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            mant_out_q  <= '0;
            exp_out_q   <= '0;
            flags_q     <= '0;
            tag_out_q   <= '0;
        end else if (s1_advance) begin
            out_valid_q <= 1'b1;
            mant_out_q  <= mant_d;
            exp_out_q   <= exp_d;
            flags_q     <= flags_d;
            tag_out_q   <= s1_tag_q;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.mant_out  = mant_out_q;
    assign bus.exp_out   = exp_out_q;
    assign bus.flags     = flags_q;
    assign bus.tag_out   = tag_out_q;

`ifdef FP_NORM_STATS_EN
    logic        out_fire;
    logic [15:0] ovf_cnt_q, unf_cnt_q, inx_cnt_q;

    assign out_fire = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
            inx_cnt_q <= '0;
        end else if (stat_clr) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
            inx_cnt_q <= '0;
        end else if (out_fire) begin
            if (flags_q[4] && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (flags_q[3] && (unf_cnt_q != 16'hFFFF)) unf_cnt_q <= unf_cnt_q + 16'd1;
            if (flags_q[2] && (inx_cnt_q != 16'hFFFF)) inx_cnt_q <= inx_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
    assign inx_cnt = inx_cnt_q;
`endif
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb/tb_fp_normalize_pipe.sv - self-checking bench for fp_normalize_pipe
module tb_fp_normalize_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fp_normalize_pipe_if #(.MANT_W(49), .EXP_W(9), .TAG_W(4)) bus ();

`ifdef FP_NORM_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] ovf_cnt, unf_cnt, inx_cnt;
    fp_normalize_pipe #(.MANT_W(49), .EXP_W(9), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stat_clr(stat_clr),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .inx_cnt(inx_cnt), .bus(bus));
`else
    fp_normalize_pipe #(.MANT_W(49), .EXP_W(9), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct packed {
        logic [48:0] mant;
        logic [8:0]  expo;
        logic [4:0]  flags;
        logic [3:0]  tag;
    } res_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: walk the mantissa up one bit at a time like a hand
    // normalization, stopping at the hidden bit or at exponent 1.
    function automatic res_t ref_norm(bit mode, logic [48:0] m, int e, logic [3:0] t);
        res_t r;
        int   maxe = mode ? 254 : 30;
        int   ee = e;
        logic [48:0] mm = m;
        bit o = 0, u = 0, x = 0, z = 0, d = 0;
        if (m == 0) begin
            z = 1; ee = 0;
        end else if (m[48]) begin
            x = m[0]; mm = m >> 1; ee = e + 1;
        end else if (e == 0) begin
            u = 1;
        end else begin
            while (!mm[47] && ee > 1) begin
                mm = mm << 1;
                ee = ee - 1;
            end
        end
        if (!z && ee > maxe) begin
            o = 1; ee = maxe + 1;
        end
        d = !z && (ee == 1) && !mm[47];
        r.mant = mm; r.expo = 9'(ee); r.flags = {o, u, x, z, d}; r.tag = t;
        return r;
    endfunction

    function automatic logic [48:0] rand_mant();
        logic [63:0] r = {$urandom, $urandom};
        int k = $urandom_range(0, 52);
        logic [48:0] m = r[48:0];
        if (k >= 49) return '0;
        return m >> k;
    endfunction

    function automatic logic [8:0] rand_exp();
        if ($urandom_range(0, 2) == 0) return 9'($urandom_range(0, 5));
        return 9'($urandom_range(0, 511));
    endfunction

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one op into an empty pipe and checks latency and result.
    task automatic run_one(input string tag, input bit mode, input logic [48:0] m,
                           input logic [8:0] e, input logic [3:0] t,
                           input logic [48:0] em, input logic [8:0] ee, input logic [4:0] ef);
        bus.mode_fp = mode; bus.mant_in = m; bus.exp_in = e; bus.tag_in = t;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, bus.out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, bus.out_valid, 1);
        check({tag, "_mant"}, bus.mant_out, em);
        check({tag, "_exp"}, bus.exp_out, ee);
        check({tag, "_flags"}, bus.flags, ef);
        check({tag, "_tag"}, bus.tag_out, t);
    endtask

    initial begin
        res_t q[$];
        res_t expr;
        logic [48:0] hold_mant;
        logic [3:0]  got_tags[$];
        int          got_cyc[$];
        int          idx;
        int          stale;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode_fp = 1'b0;
        bus.mant_in = '0; bus.exp_in = '0; bus.tag_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_mant", bus.mant_out, 0);
        check("rst_exp", bus.exp_out, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_tag", bus.tag_out, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors
        run_one("sgl_carry", 1, 49'h1_0000_0000_0000, 9'd100, 4'd1, 49'h0_8000_0000_0000, 9'd101, 5'b00000);
        run_one("sgl_shift7", 1, 49'h100_0000_0000, 9'd20, 4'd2, 49'h0_8000_0000_0000, 9'd13, 5'b00000);
        run_one("sgl_clamp", 1, 49'h100_0000_0000, 9'd4, 4'd3, 49'h800_0000_0000, 9'd1, 5'b00001);
        run_one("half_ovf", 0, 49'h1_0000_0000_0000, 9'd30, 4'd4, 49'h0_8000_0000_0000, 9'd31, 5'b10000);
        run_one("half_inx", 0, 49'h1_0000_0000_0001, 9'd10, 4'd5, 49'h0_8000_0000_0000, 9'd11, 5'b00100);
        run_one("half_zero", 0, 49'h0, 9'd17, 4'd6, 49'h0, 9'd0, 5'b00010);
        run_one("sgl_unf", 1, 49'h100_0000_0000, 9'd0, 4'd7, 49'h100_0000_0000, 9'd0, 5'b01000);
        run_one("half_ovf_ns", 0, 49'h0_8000_0000_0000, 9'd200, 4'd8, 49'h0_8000_0000_0000, 9'd31, 5'b10000);
        run_one("sgl_wrap", 1, 49'h1_0000_0000_0000, 9'd511, 4'd9, 49'h0_8000_0000_0000, 9'd255, 5'b10000);
        idle(2);

        // Backpressure: four ops, sink stalled
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (idx < 4);
            bus.tag_in = 4'(idx + 1); bus.mode_fp = 1'b1;
            bus.mant_in = 49'h0_8000_0000_0000 >> idx; bus.exp_in = 9'd50;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            if (c == 2) hold_mant = bus.mant_out;
        end
        check("bp_accepts", idx, 2);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_hold_tag", bus.tag_out, 1);
        check("bp_hold_mant", bus.mant_out, hold_mant);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (idx < 4);
            bus.tag_in = 4'(idx + 1);
            bus.mant_in = 49'h0_8000_0000_0000 >> idx;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got_tags.push_back(bus.tag_out);
                got_cyc.push_back(c);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        check("bp_drain_count", got_tags.size(), 4);
        for (int i = 0; i < got_tags.size(); i++) begin
            check($sformatf("bp_order_%0d", i), got_tags[i], i + 1);
            check($sformatf("bp_rate_%0d", i), got_cyc[i], got_cyc[0] + i);
        end
        idle(2);

        // Reset with two ops in flight
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.mode_fp = 1'b1;
        bus.mant_in = 49'h1_0000_0000_0000; bus.exp_in = 9'd60; bus.tag_in = 4'd11;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("inflight_full", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("no_stale", stale, 0);
        @(posedge clk); #1;
        run_one("post_rst", 1, 49'h100_0000_0000, 9'd20, 4'd12, 49'h0_8000_0000_0000, 9'd13, 5'b00000);
        idle(2);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.mode_fp   = 1'($urandom_range(0, 1));
            bus.mant_in   = rand_mant();
            bus.exp_in    = rand_exp();
            bus.tag_in    = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 1, 0);
                end else begin
                    expr = q.pop_front();
                    check("rnd_mant", bus.mant_out, expr.mant);
                    check("rnd_exp", bus.exp_out, expr.expo);
                    check("rnd_flags", bus.flags, expr.flags);
                    check("rnd_tag", bus.tag_out, expr.tag);
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(ref_norm(bus.mode_fp, bus.mant_in, int'(bus.exp_in), bus.tag_in));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                expr = q.pop_front();
                check("drain_mant", bus.mant_out, expr.mant);
                check("drain_flags", bus.flags, expr.flags);
                check("drain_tag", bus.tag_out, expr.tag);
            end
            @(posedge clk); #1;
        end
        check("rnd_all_drained", q.size(), 0);
        idle(2);

`ifdef FP_NORM_STATS_EN
        check("stat_base", ovf_cnt, 0);
        for (int i = 0; i < 3; i++)
            run_one("stat_ovf", 0, 49'h1_0000_0000_0000, 9'd30, 4'(i), 49'h0_8000_0000_0000, 9'd31, 5'b10000);
        @(posedge clk); #1;
        check("stat_ovf3", ovf_cnt, 3);
        run_one("stat_ovf4", 0, 49'h1_0000_0000_0000, 9'd30, 4'd3, 49'h0_8000_0000_0000, 9'd31, 5'b10000);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr_wins", ovf_cnt, 0);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.mode_fp = 1'b0;
        bus.mant_in = 49'h1_0000_0000_0000; bus.exp_in = 9'd30;
        repeat (65540) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stat_saturate", ovf_cnt, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
